pulse_event_arbiter: RTL and testbench



---
 rtl/pulse_arb_pkg.sv | 19 +
 rtl/pulse_event_arbiter_rr_pick.sv | 27 ++
 rtl/pulse_event_arbiter.sv | 82 ++++++++
 tb/tb_pulse_event_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_arb_pkg.sv
// Shared constants, FSM state type and index helper for the pulse event arbiter.
package pulse_arb_pkg;

  localparam int N     = 18;  // number of pulse channels
  localparam int IDX_W = 5;   // width of a channel index

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Next channel index with an explicit wrap at N-1; N is not a power of two,
  // so the natural 2^IDX_W rollover would produce out-of-range indices.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N - 1)) return '0;
    return i + 1'b1;
  endfunction

endpackage

// File: rtl/pulse_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`,
// searching upward with wraparound modulo N.
module rr_pick
  import pulse_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Walk last+1, last+2, ... (N steps, ending on last itself); first hit wins.
  always_comb begin
    logic [IDX_W-1:0] p;
    any = 1'b0;
    idx = '0;
    p   = last;
    for (int k = 0; k < N; k++) begin
      p = idx_inc(p);
      if (req[p] && !any) begin
        any = 1'b1;
        idx = p;
      end
    end
  end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Latches one-cycle event pulses from N channels as pending requests and
// serializes them onto one valid/ready event port in round-robin order.
// A pulse on a channel that is already pending (and not being accepted in
// that same cycle) is a lost event and sets the sticky overrun flag.
module pulse_event_arbiter
  import pulse_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     pulse,
  input  logic             ev_ready,
  input  logic             clr_overrun,
  output logic             ev_valid,
  output logic [IDX_W-1:0] ev_idx,
  output logic [N-1:0]     pending,
  output logic             overrun
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic [N-1:0]     clr_vec;
  logic             accept;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick u_pick (
    .req  (pend_q),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // State and datapath registers; reset drops every pending event at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N - 1);
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: grant from IDLE when anything is pending, return on acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pick_any) state_d = OFFER;
      OFFER: if (ev_ready) state_d = IDLE;
    endcase
  end

  // Pending/overrun update, grant capture and round-robin pointer advance.
  always_comb begin
    accept  = (state_q == OFFER) && ev_ready;
    clr_vec = '0;
    if (accept) clr_vec[idx_q] = 1'b1;
    // A pulse in the accepting cycle re-arms its own bit as a fresh event.
    pend_d  = (pend_q & ~clr_vec) | pulse;
    // Set dominates a simultaneous clear.
    ovr_d   = (|(pulse & pend_q & ~clr_vec)) | (ovr_q & ~clr_overrun);
    idx_d   = idx_q;
    last_d  = last_q;
    if (state_q == IDLE && pick_any) idx_d = pick_idx;
    if (accept) last_d = idx_q;
  end

  assign ev_valid = (state_q == OFFER);
  assign ev_idx   = idx_q;
  assign pending  = pend_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Scoreboard bench for pulse_event_arbiter: expected grant order is queued
// when pulses are driven and compared on every accepted event.
module tb_pulse_event_arbiter;
  import pulse_arb_pkg::*;

  logic             clk;
  logic             reset;
  logic [N-1:0]     pulse;
  logic             ev_ready;
  logic             clr_overrun;
  logic             ev_valid;
  logic [IDX_W-1:0] ev_idx;
  logic [N-1:0]     pending;
  logic             overrun;

  int checks;
  int failures;
  int sb_q[$];

  pulse_event_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .pulse       (pulse),
    .ev_ready    (ev_ready),
    .clr_overrun (clr_overrun),
    .ev_valid    (ev_valid),
    .ev_idx      (ev_idx),
    .pending     (pending),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (sb_q.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    chk(tag, sb_q.size(), 0);
  endtask

  // Acceptance monitor: ev_valid & ev_ready seen mid-cycle means the next edge accepts.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (sb_q.size() == 0) chk("sb_extra", int'(ev_idx), -1);
      else chk("sb_grant", int'(ev_idx), sb_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    checks = 0; failures = 0;
    reset = 1'b1; pulse = '0; ev_ready = 1'b0; clr_overrun = 1'b0;
    tick(); tick();
    chk("rst_pending", int'(pending), 0);
    chk("rst_valid",   int'(ev_valid), 0);
    chk("rst_idx",     int'(ev_idx), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    tick();

    // Single pulse on channel 3: pending after edge k, offered after k+1.
    pulse = N'(1) << 3; sb_q.push_back(3);
    tick(); pulse = '0;
    chk("single_pending", int'(pending), 'h8);
    chk("single_valid0",  int'(ev_valid), 0);
    tick();
    chk("single_valid1",  int'(ev_valid), 1);
    chk("single_idx",     int'(ev_idx), 3);
    ev_ready = 1'b1;
    tick(); ev_ready = 1'b0;
    chk("single_acc_valid",   int'(ev_valid), 0);
    chk("single_acc_pending", int'(pending), 0);

    // Fresh reset, then all channels at once: order 0..17, one per 2 cycles.
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    ev_ready = 1'b1;
    pulse = '1;
    for (int i = 0; i < N; i++) sb_q.push_back(i);
    tick(); pulse = '0;
    run_until_empty("all_drain", 80, cyc);
    chk("all_cycles",  cyc, 36);
    chk("all_pending", int'(pending), 0);
    chk("all_overrun", int'(overrun), 0);

    // last=17, only channel 0 pending -> wraps to 0.
    pulse = N'(1); sb_q.push_back(0);
    tick(); pulse = '0;
    run_until_empty("wrap17_drain", 10, cyc);
    // Move last to 5, then pending {2,9} -> 9 then 2.
    pulse = N'(1) << 5; sb_q.push_back(5);
    tick(); pulse = '0;
    run_until_empty("set5_drain", 10, cyc);
    pulse = (N'(1) << 2) | (N'(1) << 9); sb_q.push_back(9); sb_q.push_back(2);
    tick(); pulse = '0;
    run_until_empty("wrap5_drain", 20, cyc);
    chk("wrap_pending", int'(pending), 0);

    // Stall on channel 4 with repeat pulses: overrun set, idx held, clear works.
    ev_ready = 1'b0;
    pulse = N'(1) << 4; sb_q.push_back(4);
    tick(); pulse = '0;
    chk("ovr_pending", int'(pending), 'h10);
    tick();
    chk("ovr_valid", int'(ev_valid), 1);
    chk("ovr_idx0",  int'(ev_idx), 4);
    pulse = N'(1) << 4;
    tick(); pulse = '0;
    chk("ovr_set",   int'(overrun), 1);
    chk("ovr_idx1",  int'(ev_idx), 4);
    pulse = N'(1) << 4; clr_overrun = 1'b1;
    tick(); pulse = '0; clr_overrun = 1'b0;
    chk("ovr_set_wins", int'(overrun), 1);
    clr_overrun = 1'b1;
    tick(); clr_overrun = 1'b0;
    chk("ovr_clear", int'(overrun), 0);
    chk("ovr_idx2",  int'(ev_idx), 4);
    chk("ovr_valid_held", int'(ev_valid), 1);
    ev_ready = 1'b1;
    run_until_empty("ovr_drain", 10, cyc);
    tick();
    chk("ovr_pending_end", int'(pending), 0);

    // Pulse on channel 7 in its own acceptance cycle: re-armed, no overrun.
    ev_ready = 1'b0;
    pulse = (N'(1) << 7) | (N'(1) << 10); sb_q.push_back(7);
    tick(); pulse = '0;
    tick();
    chk("rearm_idx", int'(ev_idx), 7);
    ev_ready = 1'b1; pulse = N'(1) << 7;
    sb_q.push_back(10); sb_q.push_back(7);
    tick(); pulse = '0;
    chk("rearm_pending", int'(pending), 'h480);
    chk("rearm_overrun", int'(overrun), 0);
    chk("rearm_valid",   int'(ev_valid), 0);
    run_until_empty("rearm_drain", 20, cyc);

    // Asynchronous reset mid-offer with pending 0xF0 and overrun set.
    ev_ready = 1'b0;
    pulse = N'('hF0);
    tick(); pulse = '0;
    tick();
    chk("areset_valid_pre",   int'(ev_valid), 1);
    chk("areset_idx_pre",     int'(ev_idx), 4);
    chk("areset_pending_pre", int'(pending), 'hF0);
    pulse = N'(1) << 5;
    tick(); pulse = '0;
    chk("areset_ovr_pre", int'(overrun), 1);
    #1; reset = 1'b1; #1;
    chk("areset_valid",   int'(ev_valid), 0);
    chk("areset_pending", int'(pending), 0);
    chk("areset_overrun", int'(overrun), 0);
    chk("areset_idx",     int'(ev_idx), 0);
    #2; reset = 1'b0;
    tick();
    // Search restarts at channel 0: {1,17} -> 1 first, then 17.
    ev_ready = 1'b1;
    pulse = (N'(1) << 1) | (N'(1) << 17); sb_q.push_back(1); sb_q.push_back(17);
    tick(); pulse = '0;
    run_until_empty("post_reset_drain", 20, cyc);
    tick();
    chk("final_pending", int'(pending), 0);
    chk("final_overrun", int'(overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
